// File: rtl/led_pkg.sv
// Shared LED pipeline definitions: FSM encodings and bus widths
// used by the animation sequencer and the decode stage.
package led_pkg;

    localparam int LED_STATE_W = 10;
    localparam int LED_SEL_W   = 3;

    typedef enum logic [1:0] {
        LED_IDLE = 2'd0,
        LED_RUN  = 2'd1,
        LED_HOLD = 2'd2
    } led_fsm_e;

endpackage

// File: rtl/led_tick_div.sv
// Step prescaler: counts 0..CLK_DIV-1 and flags the terminal cycle.
// A held prescaler freezes in place, terminal count included.
module led_tick_div #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic hold,
    output logic tick
);

    localparam int CW = ($clog2(CLK_DIV) > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          term;

    assign term = (cnt_q == TERM);
    assign tick = term && !hold;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = term ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_anim_seq.sv
// LED animation sequencer: sweeps led_sel 0..7 LOOPS times per load,
// then parks on HOLD_SEL. All outputs are registered.
module led_anim_seq
    import led_pkg::*;
#(
    parameter int             CLK_DIV  = 250,
    parameter int             LOOPS    = 2,
    parameter logic [2:0]     HOLD_SEL = 3'd0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [LED_STATE_W-1:0] state_in,
    input  logic                   pause,
    input  logic                   clear,
    output logic [LED_STATE_W-1:0] state,
    output logic [LED_SEL_W-1:0]   led_sel,
    output logic                   busy,
    output logic                   done
);

    localparam int LW = $clog2(LOOPS + 1);

    led_fsm_e               fsm_q, fsm_d;
    logic [LED_STATE_W-1:0] state_q, state_d;
    logic [LED_SEL_W-1:0]   sel_q, sel_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [LW-1:0]          loop_q, loop_d;
    logic                   tick;
    logic                   div_restart;

    // Prescaler only runs in RUN; any restart source zeroes it.
    assign div_restart = clear || load || (fsm_q != LED_RUN);

    led_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (div_restart),
        .hold    (pause),
        .tick    (tick)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        loop_d  = loop_q;
        if (clear) begin
            fsm_d   = LED_IDLE;
            state_d = '0;
            sel_d   = '0;
            busy_d  = 1'b0;
            loop_d  = '0;
        end else if (load) begin
            fsm_d   = LED_RUN;
            state_d = state_in;
            sel_d   = '0;
            busy_d  = 1'b1;
            loop_d  = LW'(LOOPS);
        end else begin
            unique case (fsm_q)
                LED_RUN: begin
                    if (tick) begin
                        if (sel_q != '1) begin
                            sel_d = sel_q + 1'b1;
                        end else if (loop_q == LW'(1)) begin
                            fsm_d  = LED_HOLD;
                            sel_d  = HOLD_SEL;
                            busy_d = 1'b0;
                            done_d = 1'b1;
                            loop_d = '0;
                        end else begin
                            sel_d  = '0;
                            loop_d = loop_q - 1'b1;
                        end
                    end
                end
                LED_IDLE, LED_HOLD: begin
                    fsm_d = fsm_q;
                end
                default: begin
                    fsm_d = LED_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= LED_IDLE;
            state_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            loop_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            loop_q  <= loop_d;
        end
    end

    assign state   = state_q;
    assign led_sel = sel_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_led_anim_seq.sv
// Scoreboard bench for led_anim_seq: two instances (div 4 / 2 loops,
// div 1 / 1 loop) checked every cycle against a run-length model.
module tb_led_anim_seq;

    typedef struct {
        int         mode;
        int         n;
        logic [9:0] st;
        logic       dn;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [9:0] state_in;
    logic       pause;
    logic       clear;

    logic [9:0] st_a, st_b;
    logic [2:0] sel_a, sel_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int load_cyc = 0;
    int da_cyc = 0;
    int db_cyc = 0;
    int da_cnt = 0;
    int cnt0   = 0;

    mdl_t ma, mb;
    logic [14:0] qa[$];
    logic [14:0] qb[$];

    always #5 clk = ~clk;

    led_anim_seq #(.CLK_DIV(4), .LOOPS(2), .HOLD_SEL(3'd5)) u_a (
        .clk(clk), .rst_n(rst_n), .load(load), .state_in(state_in),
        .pause(pause), .clear(clear), .state(st_a), .led_sel(sel_a),
        .busy(busy_a), .done(done_a)
    );

    led_anim_seq #(.CLK_DIV(1), .LOOPS(1), .HOLD_SEL(3'd6)) u_b (
        .clk(clk), .rst_n(rst_n), .load(load), .state_in(state_in),
        .pause(pause), .clear(clear), .state(st_b), .led_sel(sel_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: n counts unpaused RUN cycles since the last load.
    function automatic mdl_t mnext(mdl_t m, int div, int loops,
                                   logic rn, logic clr, logic ld,
                                   logic ps, logic [9:0] si);
        mdl_t r;
        r = m;
        r.dn = 1'b0;
        if (!rn || clr) begin
            r.mode = 0; r.n = 0; r.st = '0;
        end else if (ld) begin
            r.mode = 1; r.n = 0; r.st = si;
        end else if (m.mode == 1 && !ps) begin
            r.n = m.n + 1;
            if (r.n == loops * 8 * div) begin
                r.mode = 2; r.dn = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [14:0] mout(mdl_t m, int div, logic [2:0] hs);
        if (m.mode == 1) return {m.st, 3'((m.n / div) % 8), 2'b10};
        if (m.mode == 2) return {m.st, hs, 1'b0, m.dn};
        return 15'd0;
    endfunction

    function automatic mdl_t mreset();
        mdl_t r;
        r.mode = 0; r.n = 0; r.st = '0; r.dn = 1'b0;
        return r;
    endfunction

    task automatic step();
        ma = mnext(ma, 4, 2, rst_n, clear, load, pause, state_in);
        mb = mnext(mb, 1, 1, rst_n, clear, load, pause, state_in);
        qa.push_back(mout(ma, 4, 3'd5));
        qb.push_back(mout(mb, 1, 3'd6));
        if (load && rst_n && !clear) load_cyc = cyc + 1;
        @(posedge clk);
        #1;
        cyc++;
        chk("sb_a", 32'({st_a, sel_a, busy_a, done_a}), 32'(qa.pop_front()));
        chk("sb_b", 32'({st_b, sel_b, busy_b, done_b}), 32'(qb.pop_front()));
        if (done_a) begin da_cnt++; da_cyc = cyc; end
        if (done_b) db_cyc = cyc;
        @(negedge clk);
        load  = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; clear = 1'b0; pause = 1'b0;
        state_in = 10'h2A5;
        ma = mreset(); mb = mreset();
        #2;
        chk("rst_a", 32'({st_a, sel_a, busy_a, done_a}), 32'd0);
        chk("rst_b", 32'({st_b, sel_b, busy_b, done_b}), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Plain run
        load = 1'b1;
        step();
        chk("load_st", 32'(st_a), 32'h2A5);
        chk("load_busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 80; i++) step();
        chk("len_a", 32'(da_cyc - load_cyc), 32'd64);
        chk("len_b", 32'(db_cyc - load_cyc), 32'd8);
        chk("done_once", 32'(da_cnt), 32'd1);
        chk("hold_sel", 32'(sel_a), 32'd5);

        // Pause 10 cycles at led_sel=3
        load = 1'b1;
        step();
        for (int i = 0; i < 64 && sel_a != 3'd3; i++) step();
        chk("reach3", 32'(sel_a), 32'd3);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("paused3", 32'(sel_a), 32'd3);
        end
        pause = 1'b0;
        cnt0 = da_cnt;
        for (int i = 0; i < 120 && da_cnt == cnt0; i++) step();
        chk("len_pause", 32'(da_cyc - load_cyc), 32'd74);

        // Reload mid-run at led_sel=5; B reloads from HOLD
        load = 1'b1;
        step();
        for (int i = 0; i < 64 && sel_a != 3'd5; i++) step();
        chk("reach5", 32'(sel_a), 32'd5);
        cnt0 = da_cnt;
        load = 1'b1;
        state_in = 10'h3FF;
        step();
        chk("reload_st", 32'(st_a), 32'h3FF);
        chk("reload_sel", 32'(sel_a), 32'd0);
        for (int i = 0; i < 120 && da_cnt == cnt0; i++) step();
        chk("len_reload", 32'(da_cyc - load_cyc), 32'd64);
        chk("one_done", 32'(da_cnt - cnt0), 32'd1);
        chk("b_reload", 32'(db_cyc - load_cyc), 32'd8);

        // clear and load together
        load = 1'b1;
        step();
        for (int i = 0; i < 6; i++) step();
        clear = 1'b1;
        load  = 1'b1;
        step();
        chk("clr_a", 32'({st_a, sel_a, busy_a}), 32'd0);
        chk("clr_b", 32'({st_b, sel_b, busy_b}), 32'd0);

        // Asynchronous reset mid-run
        load = 1'b1;
        step();
        for (int i = 0; i < 20; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a", 32'({st_a, sel_a, busy_a, done_a}), 32'd0);
        chk("arst_b", 32'({st_b, sel_b, busy_b, done_b}), 32'd0);
        ma = mreset(); mb = mreset();
        cnt0 = da_cnt;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) step();
        chk("no_done", 32'(da_cnt - cnt0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
